// File: rtl/booth_multiplier.sv
// Iterative signed WIDTH x WIDTH radix-4 Booth multiplier, one recoded digit per clock.
// Each step's add/subtract goes through a parallel-prefix (lookahead) adder.

module booth_cla #(
   parameter int N = 34
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum
);
   // Prefix only spans bits [N-2:0]; the carry out of the MSB is never needed.
   localparam int M  = N - 1;
   localparam int LV = $clog2(M);

   logic [LV:0][M-1:0] g, p;
   logic [N-1:0]       c;

   assign g[0] = a[M-1:0] & b[M-1:0];
   assign p[0] = a[M-1:0] ^ b[M-1:0];

   for (genvar k = 0; k < LV; k++) begin : g_lvl
      for (genvar i = 0; i < M; i++) begin : g_bit
         if (i >= (1 << k)) begin : g_cmb
            assign g[k+1][i] = g[k][i] | (p[k][i] & g[k][i-(1<<k)]);
            assign p[k+1][i] = p[k][i] & p[k][i-(1<<k)];
         end else begin : g_pass
            assign g[k+1][i] = g[k][i];
            assign p[k+1][i] = p[k][i];
         end
      end
   end

   assign c   = {g[LV] | (p[LV] & {M{cin}}), cin};
   assign sum = a ^ b ^ c;
endmodule

module booth_multiplier #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);
   localparam int AW = WIDTH + 2;
   localparam int PW = 2 * WIDTH + 3;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_nxt;
   logic [AW-1:0]     m;
   logic [PW-1:0]     p, p_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [AW-1:0]     addend, sum;
   logic              cin;
   logic              last;
   logic [WIDTH:0]    hi_bits;

   assign last = (state == RUN) && (cnt == CNT_W'(1));

   // Booth digit select; negative multiples are ~x with a carry-in of 1.
   always_comb begin
      addend = '0;
      cin    = 1'b0;
      case (p[2:0])
         3'b001, 3'b010: addend = m;
         3'b011:         addend = m << 1;
         3'b100:         begin addend = ~(m << 1); cin = 1'b1; end
         3'b101, 3'b110: begin addend = ~m;        cin = 1'b1; end
         default:        ;
      endcase
   end

   booth_cla #(.N(AW)) u_add (
      .a   (p[PW-1 -: AW]),
      .b   (addend),
      .cin (cin),
      .sum (sum)
   );

   assign p_nxt   = {{2{sum[AW-1]}}, sum, p[WIDTH:2]};
   // Product sits in p_nxt[2W:1]; bits [2W-1:W-1] of it must all agree to fit.
   assign hi_bits = p_nxt[2*WIDTH:WIDTH];

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (ctrl_MULT) state_nxt = RUN;
      else begin
         case (state)
            IDLE:    state_nxt = IDLE;
            RUN:     if (cnt == CNT_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      data_resultRDY = (state == DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         m              <= '0;
         p              <= '0;
         cnt            <= '0;
         data_result    <= '0;
         data_exception <= 1'b0;
      end else if (ctrl_MULT) begin
         m   <= {{2{data_operandA[WIDTH-1]}}, data_operandA};
         p   <= {{AW{1'b0}}, data_operandB, 1'b0};
         cnt <= CNT_W'(WIDTH / 2);
      end else if (state == RUN) begin
         p   <= p_nxt;
         cnt <= cnt - CNT_W'(1);
         if (last) begin
            data_result    <= p_nxt[WIDTH:1];
            data_exception <= !((&hi_bits) || (~|hi_bits));
         end
      end
   end
endmodule

// File: tb/tb_booth_multiplier.sv
// Scoreboard bench for booth_multiplier: directed cases, abort/reset corners, random pairs.

module tb_booth_multiplier;
   localparam int W = 32;

   logic         clock = 1'b0;
   logic         reset;
   logic         ctrl_MULT;
   logic [W-1:0] data_operandA, data_operandB, data_result;
   logic         data_exception, data_resultRDY;

   int errors = 0;
   int checks = 0;

   logic [W-1:0] exp_res_q[$];
   logic         exp_exc_q[$];

   logic [W-1:0] ta[5] = '{32'd6, 32'hFFFF_FFFD, 32'h8000_0000, 32'h0001_0000, 32'h7FFF_FFFF};
   logic [W-1:0] tb[5] = '{32'd7, 32'd5,         32'hFFFF_FFFF, 32'h0001_0000, 32'd1};
   logic [W-1:0] tr[5] = '{32'd42, 32'hFFFF_FFF1, 32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF};
   logic         te[5] = '{1'b0,  1'b0,          1'b1,          1'b1,          1'b0};

   booth_multiplier #(.WIDTH(W), .CNT_W(5)) dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_MULT      (ctrl_MULT),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   always #5 clock = ~clock;

   task automatic push_model(input logic [W-1:0] a, input logic [W-1:0] b);
      longint pr;
      pr = longint'($signed(a)) * longint'($signed(b));
      exp_res_q.push_back(pr[W-1:0]);
      exp_exc_q.push_back(!((pr[63:31] == 33'h0) || (pr[63:31] == {33{1'b1}})));
   endtask

   // Called at a negedge; returns at the negedge after the sampling edge.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT     = 1'b1;
      @(negedge clock);
      ctrl_MULT = 1'b0;
   endtask

   // Operands are scrambled while waiting: they must have no effect once latched.
   task automatic wait_rdy(output int lat);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         data_operandA = $urandom;
         data_operandB = $urandom;
         @(negedge clock);
         if (data_resultRDY === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; ctrl_MULT = 1'b0; data_operandA = '0; data_operandB = '0;
      repeat (3) @(negedge clock);
      checks++; if (data_result !== '0) begin errors++; $display("FAIL reset_result got %h want 0", data_result); end
      checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL reset_exc got %b want 0", data_exception); end
      checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b want 0", data_resultRDY); end
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_directed;
      int lat;
      logic [W-1:0] er;
      logic ee;
      for (int i = 0; i < 5; i++) begin
         exp_res_q.push_back(tr[i]);
         exp_exc_q.push_back(te[i]);
         start_op(ta[i], tb[i]);
         wait_rdy(lat);
         checks++; if (lat != 16) begin errors++; $display("FAIL dir%0d_latency got %0d want 16", i, lat); end
         er = exp_res_q.pop_front(); ee = exp_exc_q.pop_front();
         checks++; if (data_result !== er) begin errors++; $display("FAIL dir%0d_result got %h want %h", i, data_result, er); end
         checks++; if (data_exception !== ee) begin errors++; $display("FAIL dir%0d_exc got %b want %b", i, data_exception, ee); end
         @(negedge clock);
         checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL dir%0d_rdy_drop got %b want 0", i, data_resultRDY); end
         checks++; if (data_result !== er) begin errors++; $display("FAIL dir%0d_hold got %h want %h", i, data_result, er); end
      end
   endtask

   task automatic test_restart;
      int lat, extra;
      logic [W-1:0] er;
      start_op(32'd9, 32'd9);
      repeat (4) @(negedge clock);
      push_model(32'd2, 32'd3);
      start_op(32'd2, 32'd3);
      wait_rdy(lat);
      checks++; if (lat != 16) begin errors++; $display("FAIL restart_latency got %0d want 16", lat); end
      er = exp_res_q.pop_front(); void'(exp_exc_q.pop_front());
      checks++; if (data_result !== er) begin errors++; $display("FAIL restart_result got %h want %h", data_result, er); end
      extra = 0;
      repeat (20) begin @(negedge clock); if (data_resultRDY === 1'b1) extra++; end
      checks++; if (extra != 0) begin errors++; $display("FAIL restart_extra_rdy got %0d want 0", extra); end
   endtask

   task automatic test_held;
      int lat;
      logic [W-1:0] er;
      data_operandA = 32'd1; data_operandB = 32'd1; ctrl_MULT = 1'b1;
      @(negedge clock);
      data_operandA = 32'd2; data_operandB = 32'd2;
      @(negedge clock);
      data_operandA = 32'd4; data_operandB = 32'd5;
      push_model(32'd4, 32'd5);
      @(negedge clock);
      ctrl_MULT = 1'b0;
      wait_rdy(lat);
      checks++; if (lat != 16) begin errors++; $display("FAIL held_latency got %0d want 16", lat); end
      er = exp_res_q.pop_front(); void'(exp_exc_q.pop_front());
      checks++; if (data_result !== er) begin errors++; $display("FAIL held_result got %h want %h", data_result, er); end
      @(negedge clock);
   endtask

   task automatic test_reset_vs_ctrl;
      int rdys = 0;
      data_operandA = 32'd5; data_operandB = 32'd5;
      reset = 1'b1; ctrl_MULT = 1'b1;
      @(negedge clock);
      reset = 1'b0; ctrl_MULT = 1'b0;
      repeat (30) begin @(negedge clock); if (data_resultRDY === 1'b1) rdys++; end
      checks++; if (rdys != 0) begin errors++; $display("FAIL rst_vs_ctrl_rdy got %0d want 0", rdys); end
      checks++; if (data_result !== '0) begin errors++; $display("FAIL rst_vs_ctrl_result got %h want 0", data_result); end
   endtask

   task automatic test_reset_mid_run;
      int rdys = 0;
      start_op(32'h0000_1234, 32'h0000_5678);
      repeat (7) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      repeat (30) begin @(negedge clock); if (data_resultRDY === 1'b1) rdys++; end
      checks++; if (rdys != 0) begin errors++; $display("FAIL mid_reset_rdy got %0d want 0", rdys); end
      checks++; if (data_result !== '0) begin errors++; $display("FAIL mid_reset_result got %h want 0", data_result); end
      checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL mid_reset_exc got %b want 0", data_exception); end
   endtask

   // Each new operation starts on the DONE cycle of the previous one.
   task automatic test_back_to_back;
      int lat;
      logic [W-1:0] a, b, er;
      logic ee;
      for (int i = 0; i < 1000; i++) begin
         a = $urandom; b = $urandom;
         if (i % 4 == 1) a = W'($signed($urandom_range(0, 200)) - 100);
         if (i % 8 == 3) b = W'($signed($urandom_range(0, 200)) - 100);
         push_model(a, b);
         start_op(a, b);
         wait_rdy(lat);
         checks++; if (lat != 16) begin errors++; $display("FAIL rnd%0d_latency got %0d want 16", i, lat); end
         er = exp_res_q.pop_front(); ee = exp_exc_q.pop_front();
         checks++; if (data_result !== er) begin errors++; $display("FAIL rnd%0d_result a=%h b=%h got %h want %h", i, a, b, data_result, er); end
         checks++; if (data_exception !== ee) begin errors++; $display("FAIL rnd%0d_exc a=%h b=%h got %b want %b", i, a, b, data_exception, ee); end
      end
   endtask

   initial begin
      @(negedge clock);
      test_reset;
      test_directed;
      test_restart;
      test_held;
      test_reset_vs_ctrl;
      test_reset_mid_run;
      @(negedge clock);
      test_back_to_back;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
